reg_snapshot_ctrl: RTL and testbench
====================================

REG_SNAPSHOT_CTRL -- requirements
Module: reg_snapshot_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of checkpoint entries; legal values are powers of two, 2..16.
REQ-002 The block SHALL have parameter W, default `DATA_WIDTH, meaning the register word width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port take_snapshot, input, 1, meaning a speculative branch issues and regs_in is checkpointed.
REQ-006 The block SHALL have port regs_in, input, W x 32 array, the architectural register image from the register file.
REQ-007 The block SHALL have port resolve_valid, input, 1, meaning the oldest outstanding branch resolves this cycle.
REQ-008 The block SHALL have port resolve_mispredict, input, 1, qualified by resolve_valid, meaning the branch was mispredicted.
REQ-009 The block SHALL have port done, input, 1, the register-file acknowledgement that the snapshot restore completed.
REQ-010 The block SHALL have port recover_snapshot, output, 1, the restore request to the register file.
REQ-011 The block SHALL have port regs_snapshot, output, W x 32 array, the image to restore.
REQ-012 The block SHALL have port recovery_done_ack, output, 1, the handshake closing a restore.
REQ-013 The block SHALL have ports full, empty and busy, each an output of width 1, meaning the checkpoint store is full, the store is empty, and recovery is in progress (front end stalls).
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1, the number of valid checkpoints.
REQ-015 The block SHALL have port proto_err, output, 1, a sticky protocol-violation flag.

Function
REQ-016 The block SHALL store checkpoints in a circular FIFO with wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 to 0.
REQ-017 In IDLE, take_snapshot with full=0 SHALL write regs_in to entry wr_ptr, advance wr_ptr and increment count, with the entry becoming visible the next cycle.
REQ-018 In IDLE, resolve_valid=1 with resolve_mispredict=0 and empty=0 SHALL discard entry rd_ptr, advance rd_ptr and decrement count.
REQ-019 When take_snapshot and a correct resolve occur in the same IDLE cycle, the block SHALL perform both, leave count unchanged, and accept the push even when full=1.
REQ-020 take_snapshot with full=1 and no simultaneous pop SHALL be dropped and SHALL set proto_err.
REQ-021 resolve_valid=1 with empty=1 SHALL be ignored and SHALL set proto_err.
REQ-022 The FSM SHALL have three states: IDLE, RECOVER and ACK.
REQ-023 The FSM SHALL transition IDLE -> RECOVER on resolve_valid=1, resolve_mispredict=1 and empty=0; on this transition it SHALL latch entry rd_ptr into the regs_snapshot register.
REQ-024 When the mispredict transition to RECOVER is taken, a take_snapshot in the same cycle SHALL be ignored, because the younger instruction is squashed.
REQ-025 In RECOVER, recover_snapshot SHALL be 1 and regs_snapshot SHALL be held stable; when done=1 the FSM SHALL go to ACK.
REQ-026 In ACK, recover_snapshot SHALL be 0 and recovery_done_ack SHALL be 1; when done=0 the FSM SHALL go to IDLE.
REQ-027 On the ACK -> IDLE transition, all checkpoints SHALL be flushed: wr_ptr=rd_ptr=0 and count=0.
REQ-028 busy SHALL be 1 in RECOVER and ACK.
REQ-029 While busy=1, take_snapshot and resolve_valid SHALL be ignored without setting proto_err.
REQ-030 recover_snapshot and recovery_done_ack SHALL be registered outputs, never asserted together, and have one-cycle latency from the state change.
REQ-031 The minimum mispredict-to-IDLE time SHALL be 3 cycles: resolve, then RECOVER (done seen), then ACK (done low).
REQ-032 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both combinational from count.

Reset
REQ-033 On rst=1 the block SHALL set state=IDLE, wr_ptr=0, rd_ptr=0, count=0, recover_snapshot=0, recovery_done_ack=0, proto_err=0 and regs_snapshot all zero.
REQ-034 Stored entry contents SHALL need no reset.
REQ-035 rst asserted mid-recovery SHALL abort to IDLE with recover_snapshot=0 the next cycle; the register file is reset by the same rst.
REQ-036 rst SHALL take priority over every other input.

Verification
REQ-037 The bench SHALL cover: 2 pushes (R1=0x11, then R1=0x22) followed by 2 correct resolves -> count 0,1,2,1,0; empty=1; recover_snapshot never asserted.
REQ-038 The bench SHALL cover: push R5=0xA then R5=0xB, then a mispredict -> recover_snapshot=1 with regs_snapshot[5]=0xA; on done=1 -> recovery_done_ack=1; on done=0 -> IDLE, count=0.
REQ-039 The bench SHALL cover: DEPTH=4, 4 pushes then a 5th push alone -> count stays 4 and proto_err=1; a 5th push with a simultaneous correct resolve -> count 4, proto_err stays 0.
REQ-040 The bench SHALL cover: 6 push/pop pairs at DEPTH=4 -> pointers wrap, and the restored image matches the oldest live entry.
REQ-041 The bench SHALL cover: done held 0 for 10 cycles in RECOVER -> recover_snapshot stays 1, regs_snapshot stable, and take_snapshot ignored.
REQ-042 The bench SHALL cover: rst pulsed in ACK -> next cycle IDLE, all outputs at reset values, count=0.

Source files
------------

// File: rtl/reg_snapshot_ctrl.sv
// Branch checkpoint store: a circular FIFO of register-file images with a
// three-state restore handshake toward the register file on a mispredict.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module reg_snapshot_ctrl #(
    parameter int DEPTH = 4,
    parameter int W     = `DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     take_snapshot,
    input  logic [31:0][W-1:0]       regs_in,
    input  logic                     resolve_valid,
    input  logic                     resolve_mispredict,
    input  logic                     done,
    output logic                     recover_snapshot,
    output logic [31:0][W-1:0]       regs_snapshot,
    output logic                     recovery_done_ack,
    output logic                     full,
    output logic                     empty,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        ACK     = 2'd2
    } state_e;

    state_e                state_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         rd_ptr_d;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  recover_q;
    logic                  ack_q;
    logic                  proto_err_q;
    logic [31:0][W-1:0]    snap_q;
    logic [31:0][W-1:0]    mem_q [DEPTH];

    logic idle;
    logic res_ok;
    logic mispred;
    logic pop;
    logic push;
    logic err_set;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign busy  = (state_q != IDLE);
    assign count = count_q;

    assign recover_snapshot  = recover_q;
    assign recovery_done_ack = ack_q;
    assign regs_snapshot     = snap_q;
    assign proto_err         = proto_err_q;

    // A mispredict squashes any same-cycle push; a pop frees room for a push.
    always_comb begin
        idle    = (state_q == IDLE);
        res_ok  = resolve_valid && !empty;
        mispred = idle && res_ok && resolve_mispredict;
        pop     = idle && res_ok && !resolve_mispredict;
        push    = idle && take_snapshot && !mispred && (!full || pop);
        err_set = idle && ((take_snapshot && full && !pop && !mispred)
                           || (resolve_valid && empty));
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= regs_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            recover_q   <= 1'b0;
            ack_q       <= 1'b0;
            proto_err_q <= 1'b0;
            snap_q      <= '0;
        end else begin
            if (err_set) begin
                proto_err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (mispred) begin
                        state_q   <= RECOVER;
                        recover_q <= 1'b1;
                        snap_q    <= mem_q[rd_ptr_q];
                    end else begin
                        wr_ptr_q <= wr_ptr_d;
                        rd_ptr_q <= rd_ptr_d;
                        count_q  <= count_d;
                    end
                end
                RECOVER: begin
                    if (done) begin
                        state_q   <= ACK;
                        recover_q <= 1'b0;
                        ack_q     <= 1'b1;
                    end
                end
                ACK: begin
                    // All younger checkpoints are stale once the restore closes.
                    if (!done) begin
                        state_q  <= IDLE;
                        ack_q    <= 1'b0;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        count_q  <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    recover_q <= 1'b0;
                    ack_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_snapshot_ctrl.sv
// Self-checking bench for reg_snapshot_ctrl against a queue-based model.
module tb_reg_snapshot_ctrl;

    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [31:0][W-1:0] img_t;
    typedef enum {M_IDLE, M_REC, M_ACK} mode_e;

    logic          clk = 1'b0;
    logic          rst;
    logic          take_snapshot;
    img_t          regs_in;
    logic          resolve_valid;
    logic          resolve_mispredict;
    logic          done;
    logic          recover_snapshot;
    img_t          regs_snapshot;
    logic          recovery_done_ack;
    logic          full;
    logic          empty;
    logic          busy;
    logic [CW-1:0] count;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    img_t  mq[$];
    mode_e m_mode = M_IDLE;
    img_t  m_snap = '0;
    bit    m_err  = 1'b0;

    always #5 clk = ~clk;

    reg_snapshot_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .take_snapshot     (take_snapshot),
        .regs_in           (regs_in),
        .resolve_valid     (resolve_valid),
        .resolve_mispredict(resolve_mispredict),
        .done              (done),
        .recover_snapshot  (recover_snapshot),
        .regs_snapshot     (regs_snapshot),
        .recovery_done_ack (recovery_done_ack),
        .full              (full),
        .empty             (empty),
        .busy              (busy),
        .count             (count),
        .proto_err         (proto_err)
    );

    function automatic img_t rand_img();
        img_t v;
        for (int i = 0; i < 32; i++) v[i] = W'($urandom);
        return v;
    endfunction

    function automatic int first_diff(input img_t a, input img_t b);
        for (int i = 0; i < 32; i++) if (a[i] !== b[i]) return i;
        return 0;
    endfunction

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic cycle(input bit r, input bit tk, input img_t img,
                         input bit rv, input bit rm, input bit dn);
        rst = r;
        take_snapshot = tk;
        regs_in = img;
        resolve_valid = rv;
        resolve_mispredict = rm;
        done = dn;
        if (r) begin
            mq.delete();
            m_mode = M_IDLE;
            m_snap = '0;
            m_err  = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (rv) begin
                        if (mq.size() == 0) m_err = 1'b1;
                        else if (rm) begin
                            m_snap = mq[0];
                            m_mode = M_REC;
                        end else void'(mq.pop_front());
                    end
                    if (tk && m_mode == M_IDLE) begin
                        if (mq.size() < DEPTH) mq.push_back(img);
                        else m_err = 1'b1;
                    end
                end
                M_REC: if (dn) m_mode = M_ACK;
                default: if (!dn) begin
                    m_mode = M_IDLE;
                    mq.delete();
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input img_t img);
        cycle(1'b0, 1'b1, img, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, rand_img(), 1'b1, 1'b1, 1'b1);
        checks++;
        if (count !== '0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", count);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got e%b f%b b%b exp e1 f0 b0",
                     empty, full, busy);
        end
        checks++;
        if (recover_snapshot !== 1'b0 || recovery_done_ack !== 1'b0
            || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs got r%b a%b p%b exp 000",
                     recover_snapshot, recovery_done_ack, proto_err);
        end
        checks++;
        if (regs_snapshot !== '0) begin
            errors++; $display("FAIL reset_snapshot got nonzero exp 0");
        end
    endtask

    task automatic test_push_pop();
        img_t a = rand_img();
        img_t b = rand_img();
        int exp_cnt[4] = '{1, 2, 1, 0};
        bit seen_rec = 1'b0;
        a[1] = 32'h11;
        b[1] = 32'h22;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) push(a);
            else if (i == 1) push(b);
            else cycle(1'b0, 1'b0, rand_img(), 1'b1, 1'b0, 1'b0);
            seen_rec |= recover_snapshot;
            checks++;
            if (count !== CW'(exp_cnt[i])) begin
                errors++;
                $display("FAIL pushpop_count step %0d got %0d exp %0d",
                         i, count, exp_cnt[i]);
            end
        end
        checks++;
        if (empty !== 1'b1 || seen_rec !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_end got empty %b rec %b exp 1 0",
                     empty, seen_rec);
        end
    endtask

    task automatic test_mispredict();
        img_t a = rand_img();
        img_t b = rand_img();
        a[5] = 32'hA;
        b[5] = 32'hB;
        push(a);
        push(b);
        cycle(1'b0, 1'b0, rand_img(), 1'b1, 1'b1, 1'b0);
        checks++;
        if (recover_snapshot !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mispred_rec got r%b b%b exp 11",
                     recover_snapshot, busy);
        end
        checks++;
        if (regs_snapshot[5] !== 32'hA) begin
            errors++;
            $display("FAIL mispred_r5 got %h exp 0000000a", regs_snapshot[5]);
        end
        cycle(1'b0, 1'b0, rand_img(), 1'b0, 1'b0, 1'b1);
        checks++;
        if (recovery_done_ack !== 1'b1 || recover_snapshot !== 1'b0) begin
            errors++;
            $display("FAIL mispred_ack got a%b r%b exp a1 r0",
                     recovery_done_ack, recover_snapshot);
        end
        cycle(1'b0, 1'b0, rand_img(), 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || count !== '0 || recovery_done_ack !== 1'b0) begin
            errors++;
            $display("FAIL mispred_idle got b%b c%0d a%b exp b0 c0 a0",
                     busy, count, recovery_done_ack);
        end
    endtask

    task automatic test_full();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) push(rand_img());
        checks++;
        if (count !== CW'(DEPTH) || full !== 1'b1) begin
            errors++;
            $display("FAIL full_fill got c%0d f%b exp c%0d f1", count, full, DEPTH);
        end
        cycle(1'b0, 1'b1, rand_img(), 1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(DEPTH) || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL full_pair got c%0d p%b exp c%0d p0",
                     count, proto_err, DEPTH);
        end
        cycle(1'b0, 1'b1, rand_img(), 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(DEPTH) || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL full_drop got c%0d p%b exp c%0d p1",
                     count, proto_err, DEPTH);
        end
        cycle(1'b0, 1'b0, rand_img(), 1'b1, 1'b1, 1'b0);
        checks++;
        if (regs_snapshot !== m_snap) begin
            errors++;
            $display("FAIL full_image reg %0d got %h exp %h",
                     first_diff(regs_snapshot, m_snap),
                     regs_snapshot[first_diff(regs_snapshot, m_snap)],
                     m_snap[first_diff(regs_snapshot, m_snap)]);
        end
        cycle(1'b0, 1'b0, rand_img(), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, rand_img(), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        push(rand_img());
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, rand_img(), 1'b1, 1'b0, 1'b0);
            checks++;
            if (count !== CW'(1) || proto_err !== 1'b0) begin
                errors++;
                $display("FAIL wrap_pair %0d got c%0d p%b exp c1 p0",
                         i, count, proto_err);
            end
        end
        push(rand_img());
        cycle(1'b0, 1'b0, rand_img(), 1'b1, 1'b1, 1'b0);
        checks++;
        if (regs_snapshot !== m_snap) begin
            errors++;
            $display("FAIL wrap_image reg %0d got %h exp %h",
                     first_diff(regs_snapshot, m_snap),
                     regs_snapshot[first_diff(regs_snapshot, m_snap)],
                     m_snap[first_diff(regs_snapshot, m_snap)]);
        end
        cycle(1'b0, 1'b0, rand_img(), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, rand_img(), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        push(rand_img());
        push(rand_img());
        cycle(1'b0, 1'b1, rand_img(), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, rand_img(), ($urandom % 2) == 1,
                  ($urandom % 2) == 1, 1'b0);
            checks++;
            if (recover_snapshot !== 1'b1 || regs_snapshot !== m_snap
                || count !== CW'(2) || proto_err !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d got r%b c%0d p%b snapok%b exp r1 c2 p0 snapok1",
                         i, recover_snapshot, count, proto_err,
                         regs_snapshot === m_snap);
            end
        end
        cycle(1'b0, 1'b0, rand_img(), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, rand_img(), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_rst_in_ack();
        cycle(1'b0, 1'b0, rand_img(), 1'b1, 1'b0, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL empty_resolve got p%b c%0d exp p1 c0", proto_err, count);
        end
        push(rand_img());
        cycle(1'b0, 1'b0, rand_img(), 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, rand_img(), 1'b0, 1'b0, 1'b1);
        checks++;
        if (recovery_done_ack !== 1'b1) begin
            errors++; $display("FAIL ack_state got %b exp 1", recovery_done_ack);
        end
        cycle(1'b1, 1'b1, rand_img(), 1'b1, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b0 || recover_snapshot !== 1'b0
            || recovery_done_ack !== 1'b0 || proto_err !== 1'b0
            || count !== '0 || empty !== 1'b1 || regs_snapshot !== '0) begin
            errors++;
            $display("FAIL rst_ack got b%b r%b a%b p%b c%0d e%b snapzero%b",
                     busy, recover_snapshot, recovery_done_ack, proto_err,
                     count, empty, regs_snapshot === '0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit r  = ($urandom % 97) == 0;
            bit tk = ($urandom % 2) == 1;
            bit rv = ($urandom % 10) < 4;
            bit rm = ($urandom % 5) == 0;
            bit dn = (m_mode == M_REC) ? (($urandom % 3) == 0)
                                       : (($urandom % 2) == 1);
            cycle(r, tk, rand_img(), rv, rm, dn);
            checks++;
            if (count !== CW'(mq.size())
                || full !== (mq.size() == DEPTH)
                || empty !== (mq.size() == 0)
                || busy !== (m_mode != M_IDLE)
                || recover_snapshot !== (m_mode == M_REC)
                || recovery_done_ack !== (m_mode == M_ACK)
                || proto_err !== m_err) begin
                errors++;
                $display("FAIL rand_%0d got c%0d f%b e%b b%b r%b a%b p%b exp c%0d mode%0d p%b",
                         n, count, full, empty, busy, recover_snapshot,
                         recovery_done_ack, proto_err, mq.size(), m_mode, m_err);
            end
            checks++;
            if (regs_snapshot !== m_snap) begin
                errors++;
                $display("FAIL rand_snap_%0d reg %0d got %h exp %h", n,
                         first_diff(regs_snapshot, m_snap),
                         regs_snapshot[first_diff(regs_snapshot, m_snap)],
                         m_snap[first_diff(regs_snapshot, m_snap)]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        take_snapshot = 1'b0;
        regs_in = '0;
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        done = 1'b0;
        test_reset();
        test_push_pop();
        test_mispredict();
        test_full();
        test_wrap();
        test_stall();
        test_rst_in_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
